piso_serializer: RTL and testbench

//   Parallel-in/serial-out transmitter. The mate of the 8-bit serial-in/parallel-out register (D -> Q[7:0]).

---
 rtl/piso_serializer.sv | 82 ++++++++
 tb/tb_piso_serializer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: streams a WIDTH-bit word on Q, one bit per clock, with Valid/Done.
// Latency: first bit on Q the cycle after acceptance; Ready only when idle or on the last bit, busy Loads dropped.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  output logic             Ready,
  output logic             Q,
  output logic             Valid,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, shifted;
  logic [CW-1:0]    count, count_nxt;
  logic             last;

  // Zeros shift in behind the word, so shreg is already clear when the block falls back to IDLE.
  assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  assign last  = (state == SHIFT) && (count == LAST);
  assign Ready = (state == IDLE) || last;
  assign Valid = (state == SHIFT);
  assign Done  = last;
  assign Q     = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (Load) begin
          state_nxt = SHIFT;
          shreg_nxt = Din;
          count_nxt = '0;
        end
      end
      SHIFT: begin
        if (count == LAST) begin
          count_nxt = '0;
          if (Load) begin
            shreg_nxt = Din;
          end else begin
            state_nxt = IDLE;
            shreg_nxt = shifted;
          end
        end else begin
          count_nxt = count + 1'b1;
          shreg_nxt = shifted;
        end
      end
      default: begin
        state_nxt = IDLE;
        shreg_nxt = '0;
        count_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances plus a behavioural SIPO receiver on the MSB-first stream.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_m, load_l;
  logic [7:0] din_m, din_l;
  logic       ready_m, q_m, valid_m, done_m;
  logic       ready_l, q_l, valid_l, done_l;
  logic [7:0] rx = 8'h00;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .Clk(clk), .Rst_n(rst_n), .Load(load_m), .Din(din_m),
    .Ready(ready_m), .Q(q_m), .Valid(valid_m), .Done(done_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .Clk(clk), .Rst_n(rst_n), .Load(load_l), .Din(din_l),
    .Ready(ready_l), .Q(q_l), .Valid(valid_l), .Done(done_l)
  );

  // receiver: 8-bit serial-in register fed by Q, clocked only on valid bits
  always @(posedge clk) if (valid_m) rx <= {rx[6:0], q_m};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_m(input string tag);
    chk({tag, ".q"}, q_m, 0);
    chk({tag, ".valid"}, valid_m, 0);
    chk({tag, ".done"}, done_m, 0);
    chk({tag, ".ready"}, ready_m, 1);
  endtask

  // Caller has set load_m/din_m for word w at a negedge. Checks its 8 bits; optionally
  // chains the next word on the Done cycle, or pokes a 0xFF load while busy at bit drop_at.
  task automatic send_m(input string tag, input logic [7:0] w, input bit chain,
                        input logic [7:0] nxt, input int drop_at);
    logic [7:0] ww;
    ww = w;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0 || i == drop_at + 1) load_m = 1'b0;
      chk($sformatf("%s.q%0d", tag, i), q_m, ww[7-i]);
      chk($sformatf("%s.valid%0d", tag, i), valid_m, 1);
      chk($sformatf("%s.done%0d", tag, i), done_m, (i == 7) ? 1 : 0);
      chk($sformatf("%s.ready%0d", tag, i), ready_m, (i == 7) ? 1 : 0);
      if (i == drop_at) begin
        load_m = 1'b1;
        din_m  = 8'hFF;
      end
      if (i == 7 && chain) begin
        load_m = 1'b1;
        din_m  = nxt;
      end
    end
  endtask

  initial begin
    logic [7:0] wl;
    rst_n  = 1'b0;
    load_m = 1'b1;
    din_m  = 8'hA5;
    load_l = 1'b0;
    din_l  = 8'h00;

    // 1: reset with Load held high stays idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_m("rst");
    chk("rst.l_valid", valid_l, 0);
    rst_n  = 1'b1;
    load_m = 1'b0;
    @(negedge clk);
    chk_idle_m("rst_rel");

    // 2: single word A5, then idle; receiver holds the word
    load_m = 1'b1;
    din_m  = 8'hA5;
    send_m("single", 8'hA5, 1'b0, 8'h00, -10);
    @(negedge clk);
    chk_idle_m("single_end");
    chk("loop_a5", rx, 8'hA5);

    // 3: gapless A5 then 3C
    load_m = 1'b1;
    din_m  = 8'hA5;
    send_m("b2b0", 8'hA5, 1'b1, 8'h3C, -10);
    send_m("b2b1", 8'h3C, 1'b0, 8'h00, -10);
    @(negedge clk);
    chk_idle_m("b2b_end");
    chk("loop_3c", rx, 8'h3C);

    // 4: load while busy at count=3 is dropped
    load_m = 1'b1;
    din_m  = 8'h5A;
    send_m("drop", 8'h5A, 1'b0, 8'h00, 3);
    @(negedge clk);
    chk_idle_m("drop_end");
    @(negedge clk);
    chk_idle_m("drop_end2");

    // 5: reset after the 4th bit of F0 aborts it
    load_m = 1'b1;
    din_m  = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load_m = 1'b0;
      chk($sformatf("abort.q%0d", i), q_m, 1);
      chk($sformatf("abort.done%0d", i), done_m, 0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_m("abort_rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_m("abort_after");
    load_m = 1'b1;
    din_m  = 8'h81;
    send_m("post", 8'h81, 1'b0, 8'h00, -10);
    @(negedge clk);
    chk_idle_m("post_end");

    // 6: LSB-first, 01 -> 1 then seven 0s; Din changes after capture
    load_l = 1'b1;
    din_l  = 8'h01;
    wl     = 8'h01;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load_l = 1'b0;
      din_l  = 8'hFF;
      chk($sformatf("lsb.q%0d", i), q_l, wl[i]);
      chk($sformatf("lsb.valid%0d", i), valid_l, 1);
      chk($sformatf("lsb.done%0d", i), done_l, (i == 7) ? 1 : 0);
    end
    @(negedge clk);
    chk("lsb_end.valid", valid_l, 0);
    chk("lsb_end.ready", ready_l, 1);
    chk("lsb_end.q", q_l, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
